ifid_skid_stage: RTL and testbench

- IF/ID pipeline stage register for the 5-stage MIPS pipeline.
- Consumes the hazard unit's advance enable (ifd_wr) and the branch/jump flush (flush_br).
- Holds a one-entry skid buffer so a fetch already in flight during a load-use stall is never lost.
- Presents the decoded rs/rt fields back to the hazard unit, and counts stall cycles for performance monitoring.

---
 rtl/ifid_skid_stage.sv | 120 ++++++++++++
 tb/tb_ifid_skid_stage.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ifid_skid_stage.sv
// IF/ID pipeline register with a one-entry skid buffer, hazard-unit stall/flush
// handling, rs/rt feedback and a saturating stall-cycle counter.
module ifid_skid_stage #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid,
    input  logic [DATA_W-1:0] if_inst,
    input  logic [PC_W-1:0]   if_pc4,
    output logic              if_ready,
    input  logic              ifd_wr,
    input  logic              flush_br,
    output logic              id_valid,
    output logic [DATA_W-1:0] id_inst,
    output logic [PC_W-1:0]   id_pc4,
    output logic [4:0]        id_rs,
    output logic [4:0]        id_rt,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              main_valid_q, main_valid_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] main_inst_q,  main_inst_d;
    logic [PC_W-1:0]   main_pc4_q,   main_pc4_d;
    logic [DATA_W-1:0] skid_inst_q,  skid_inst_d;
    logic [PC_W-1:0]   skid_pc4_q,   skid_pc4_d;
    logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;
    logic              accept;

    // Ready depends only on the skid register, so ifd_wr never reaches if_ready.
    assign if_ready = !skid_valid_q;
    assign accept   = if_valid & if_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_inst_d  = main_inst_q;
        main_pc4_d   = main_pc4_q;
        skid_inst_d  = skid_inst_q;
        skid_pc4_d   = skid_pc4_q;
        stall_cnt_d  = stall_cnt_q;

        if (flush_br) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            main_inst_d  = '0;
            main_pc4_d   = '0;
        end else begin
            unique case ({main_valid_q, skid_valid_q})
                2'b00: begin
                    if (accept) begin
                        main_valid_d = 1'b1;
                        main_inst_d  = if_inst;
                        main_pc4_d   = if_pc4;
                    end
                end
                2'b10: begin
                    if (ifd_wr) begin
                        if (accept) begin
                            main_inst_d = if_inst;
                            main_pc4_d  = if_pc4;
                        end else begin
                            main_valid_d = 1'b0;
                        end
                    end else if (accept) begin
                        skid_valid_d = 1'b1;
                        skid_inst_d  = if_inst;
                        skid_pc4_d   = if_pc4;
                    end
                end
                2'b11: begin
                    if (ifd_wr) begin
                        main_inst_d  = skid_inst_q;
                        main_pc4_d   = skid_pc4_q;
                        skid_valid_d = 1'b0;
                    end
                end
                default: begin
                    // Unreachable skid-without-main encoding: recover to EMPTY.
                    main_valid_d = 1'b0;
                    skid_valid_d = 1'b0;
                end
            endcase
        end

        if (main_valid_q && !ifd_wr && !flush_br && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_inst_q  <= '0;
            main_pc4_q   <= '0;
            skid_inst_q  <= '0;
            skid_pc4_q   <= '0;
            stall_cnt_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_inst_q  <= main_inst_d;
            main_pc4_q   <= main_pc4_d;
            skid_inst_q  <= skid_inst_d;
            skid_pc4_q   <= skid_pc4_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign id_valid  = main_valid_q;
    assign id_inst   = main_valid_q ? main_inst_q : '0;
    assign id_pc4    = main_valid_q ? main_pc4_q  : '0;
    assign id_rs     = main_valid_q ? main_inst_q[25:21] : 5'd0;
    assign id_rt     = main_valid_q ? main_inst_q[20:16] : 5'd0;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_ifid_skid_stage.sv
// Directed bench for ifid_skid_stage: streaming, load-use skid, flushes,
// stall counter saturation and asynchronous reset.
module tb_ifid_skid_stage;

    localparam int DATA_W = 32;
    localparam int PC_W   = 32;
    localparam int CNT_W  = 16;

    localparam logic [31:0] INST_A = 32'h8C22_0004;
    localparam logic [31:0] INST_B = 32'h0022_1820;
    localparam logic [31:0] INST_C = 32'h0042_1820;

    logic              clk;
    logic              rst_n;
    logic              if_valid;
    logic [DATA_W-1:0] if_inst;
    logic [PC_W-1:0]   if_pc4;
    logic              if_ready;
    logic              ifd_wr;
    logic              flush_br;
    logic              id_valid;
    logic [DATA_W-1:0] id_inst;
    logic [PC_W-1:0]   id_pc4;
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic [CNT_W-1:0]  stall_cnt;

    int checks   = 0;
    int failures = 0;

    ifid_skid_stage #(.DATA_W(DATA_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_valid(if_valid), .if_inst(if_inst), .if_pc4(if_pc4), .if_ready(if_ready),
        .ifd_wr(ifd_wr), .flush_br(flush_br),
        .id_valid(id_valid), .id_inst(id_inst), .id_pc4(id_pc4),
        .id_rs(id_rs), .id_rt(id_rt), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc4,
                         input logic wr, input logic fl);
        if_valid = v;
        if_inst  = inst;
        if_pc4   = pc4;
        ifd_wr   = wr;
        flush_br = fl;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        #2;
        check("rst_id_valid", 64'(id_valid), 64'd0);
        check("rst_if_ready", 64'(if_ready), 64'd1);
        check("rst_id_inst", 64'(id_inst), 64'd0);
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        step();
        step();
        rst_n = 1'b1;

        // Streaming at full rate
        drive(1'b1, INST_A, 32'h4, 1'b1, 1'b0);
        step();
        check("s1_id_inst", 64'(id_inst), 64'(INST_A));
        check("s1_id_pc4", 64'(id_pc4), 64'h4);
        check("s1_id_rs", 64'(id_rs), 64'd1);
        check("s1_id_rt", 64'(id_rt), 64'd2);
        check("s1_if_ready", 64'(if_ready), 64'd1);
        drive(1'b1, INST_B, 32'h8, 1'b1, 1'b0);
        step();
        check("s2_id_inst", 64'(id_inst), 64'(INST_B));
        check("s2_id_rs", 64'(id_rs), 64'd1);
        check("s2_id_rt", 64'(id_rt), 64'd2);
        check("s2_if_ready", 64'(if_ready), 64'd1);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        check("s3_drain_valid", 64'(id_valid), 64'd0);
        check("s3_drain_inst", 64'(id_inst), 64'd0);

        // Load-use stall with a fetch caught in the skid slot
        drive(1'b1, INST_A, 32'h10, 1'b1, 1'b0);
        step();
        drive(1'b1, INST_C, 32'h14, 1'b0, 1'b0);
        step();
        check("lu1_if_ready", 64'(if_ready), 64'd0);
        check("lu1_id_inst", 64'(id_inst), 64'(INST_A));
        check("lu1_stall_cnt", 64'(stall_cnt), 64'd1);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        check("lu2_id_inst", 64'(id_inst), 64'(INST_A));
        check("lu2_stall_cnt", 64'(stall_cnt), 64'd2);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        check("lu3_id_inst", 64'(id_inst), 64'(INST_C));
        check("lu3_id_pc4", 64'(id_pc4), 64'h14);
        check("lu3_id_rs", 64'(id_rs), 64'd2);
        check("lu3_if_ready", 64'(if_ready), 64'd1);
        check("lu3_stall_cnt", 64'(stall_cnt), 64'd2);
        step();
        check("lu4_drain_valid", 64'(id_valid), 64'd0);

        // Flush while in SKID
        drive(1'b1, INST_A, 32'h20, 1'b1, 1'b0);
        step();
        drive(1'b1, INST_C, 32'h24, 1'b0, 1'b0);
        step();
        check("fs_pre_if_ready", 64'(if_ready), 64'd0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        step();
        check("fs_id_valid", 64'(id_valid), 64'd0);
        check("fs_id_inst", 64'(id_inst), 64'd0);
        check("fs_if_ready", 64'(if_ready), 64'd1);
        check("fs_stall_cnt", 64'(stall_cnt), 64'd3);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("fs_no_ghost", 64'(id_valid), 64'd0);
        end

        // Flush in FULL coinciding with an accepted fetch
        drive(1'b1, INST_A, 32'h30, 1'b1, 1'b0);
        step();
        drive(1'b1, INST_B, 32'h34, 1'b1, 1'b1);
        step();
        check("ff_id_valid", 64'(id_valid), 64'd0);
        check("ff_id_rs", 64'(id_rs), 64'd0);
        check("ff_id_rt", 64'(id_rt), 64'd0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        check("ff_no_ghost", 64'(id_valid), 64'd0);

        // Asynchronous reset in the middle of a SKID stall
        drive(1'b1, INST_A, 32'h40, 1'b1, 1'b0);
        step();
        drive(1'b1, INST_C, 32'h44, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_id_valid", 64'(id_valid), 64'd0);
        check("ar_id_inst", 64'(id_inst), 64'd0);
        check("ar_id_pc4", 64'(id_pc4), 64'd0);
        check("ar_id_rs_rt", 64'({id_rs, id_rt}), 64'd0);
        check("ar_if_ready", 64'(if_ready), 64'd1);
        check("ar_stall_cnt", 64'(stall_cnt), 64'd0);
        step();
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("ar_no_stale", 64'(id_valid), 64'd0);
        end

        // Counter saturation: 0xFFFE stall cycles, then 5 more
        drive(1'b1, INST_A, 32'h50, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 16'hFFFE; i++) step();
        check("sat_preload", 64'(stall_cnt), 64'hFFFE);
        for (int i = 0; i < 5; i++) begin
            step();
            check("sat_hold", 64'(stall_cnt), 64'hFFFF);
        end
        check("sat_id_inst", 64'(id_inst), 64'(INST_A));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
